// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command per handshake, sequences the operand loads,
// supervises the multi-cycle product unit and returns results with a flag snapshot.
module alu_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic        cmd_v,
    input  logic        cmd_flop,
    input  logic [2:0]  cmd_opfl,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [15:0] cmd_d,
    output logic [15:0] alu_A,
    output logic        alu_WA,
    output logic        alu_WB,
    output logic        alu_WD,
    output logic [5:0]  alu_op,
    output logic        alu_V,
    output logic [1:0]  alu_WR,
    output logic        alu_ENADi,
    output logic [2:0]  alu_opFL,
    input  logic [15:0] alu_R1,
    input  logic [15:0] alu_R2,
    input  logic [5:0]  alu_FL,
    input  logic        alu_FINP,
    output logic        res_valid,
    output logic [15:0] res1,
    output logic [15:0] res2,
    output logic [5:0]  res_fl,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDA   = 3'd1,
        S_LDB   = 3'd2,
        S_LDD   = 3'd3,
        S_EXEC  = 3'd4,
        S_WAITP = 3'd5,
        S_FLG   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    function automatic logic is_prod(input logic [5:0] op);
        return op[5:3] == 3'b100;
    endfunction

    function automatic logic is_unary(input logic [5:0] op);
        return op[5:3] == 3'b101;
    endfunction

    function automatic logic is_needd(input logic [5:0] op);
        return (op == 6'b100101) || (op == 6'b100111);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [5:0]      op_r;
    logic            flop_r;
    logic [2:0]      opfl_r;
    logic [15:0]     a_r, b_r, d_r;

    logic            accept_s, commit_s, err_nxt_s;
    logic [5:0]      op_s, op_nxt_s, fl_nxt_s;
    logic            flop_s;
    logic [2:0]      opfl_s, opfl_nxt_s;
    logic [15:0]     a_s, b_s, d_s, a_nxt_s, res1_nxt_s, res2_nxt_s;
    logic            wa_nxt_s, wb_nxt_s, wd_nxt_s, en_nxt_s;
    logic [1:0]      wr_nxt_s;

    // The accepting cycle works on the live command, later states on the latched copy.
    assign accept_s = (state_r == S_IDLE) && cmd_valid;
    assign op_s     = accept_s ? cmd_op   : op_r;
    assign flop_s   = accept_s ? cmd_flop : flop_r;
    assign opfl_s   = accept_s ? cmd_opfl : opfl_r;
    assign a_s      = accept_s ? cmd_a    : a_r;
    assign b_s      = accept_s ? cmd_b    : b_r;
    assign d_s      = accept_s ? cmd_d    : d_r;

    // Next state, result capture and next values of every registered ALU control
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        res1_nxt_s  = res1;
        res2_nxt_s  = res2;
        err_nxt_s   = 1'b0;
        commit_s    = 1'b0;
        a_nxt_s     = 16'h0000;
        wa_nxt_s    = 1'b0;
        wb_nxt_s    = 1'b0;
        wd_nxt_s    = 1'b0;
        en_nxt_s    = 1'b0;
        wr_nxt_s    = 2'b00;
        opfl_nxt_s  = 3'b000;
        op_nxt_s    = 6'b000000;
        fl_nxt_s    = res_fl;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = cmd_flop ? S_FLG : S_LDA;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LDA:  state_nxt_s = is_unary(op_r) ? S_EXEC : S_LDB;
            S_LDB:  state_nxt_s = is_needd(op_r) ? S_LDD : S_EXEC;
            S_LDD:  state_nxt_s = S_EXEC;
            S_EXEC: begin
                if (is_prod(op_r)) begin
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = S_WAITP;
                end else begin
                    res1_nxt_s  = alu_R1;
                    res2_nxt_s  = 16'h0000;
                    state_nxt_s = S_DONE;
                end
            end
            S_WAITP: begin
                cnt_nxt_s = cnt_r + CW'(1);
                // A done pulse on the last allowed cycle still wins over the timeout.
                if (alu_FINP) begin
                    res1_nxt_s  = alu_R1;
                    res2_nxt_s  = alu_R2;
                    commit_s    = 1'b1;
                    state_nxt_s = S_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    res1_nxt_s  = 16'h0000;
                    res2_nxt_s  = 16'h0000;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_WAITP;
                end
            end
            S_FLG: begin
                res1_nxt_s  = 16'h0000;
                res2_nxt_s  = 16'h0000;
                state_nxt_s = S_DONE;
            end
            S_DONE: begin
                err_nxt_s   = err;
                state_nxt_s = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase

        case (state_nxt_s)
            S_LDA: begin
                a_nxt_s  = a_s;
                wa_nxt_s = 1'b1;
            end
            S_LDB: begin
                a_nxt_s  = b_s;
                wb_nxt_s = 1'b1;
            end
            S_LDD: begin
                a_nxt_s  = d_s;
                wd_nxt_s = 1'b1;
            end
            S_EXEC: begin
                if (is_prod(op_s)) begin
                    en_nxt_s = 1'b1;
                end else begin
                    wr_nxt_s = 2'b01;
                end
            end
            S_FLG:  opfl_nxt_s = opfl_s;
            S_DONE: begin
                wr_nxt_s = commit_s ? 2'b01 : 2'b00;
                fl_nxt_s = alu_FL;
            end
            default: a_nxt_s = 16'h0000;
        endcase

        if ((state_nxt_s == S_IDLE) || flop_s) begin
            op_nxt_s = 6'b000000;
        end else begin
            op_nxt_s = op_s;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CW{1'b0}};
            cmd_ready <= 1'b1;
            alu_A     <= 16'h0000;
            alu_WA    <= 1'b0;
            alu_WB    <= 1'b0;
            alu_WD    <= 1'b0;
            alu_op    <= 6'b000000;
            alu_V     <= 1'b0;
            alu_WR    <= 2'b00;
            alu_ENADi <= 1'b0;
            alu_opFL  <= 3'b000;
            res_valid <= 1'b0;
            res1      <= 16'h0000;
            res2      <= 16'h0000;
            res_fl    <= 6'b000000;
            err       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            cmd_ready <= (state_nxt_s == S_IDLE);
            alu_A     <= a_nxt_s;
            alu_WA    <= wa_nxt_s;
            alu_WB    <= wb_nxt_s;
            alu_WD    <= wd_nxt_s;
            alu_op    <= op_nxt_s;
            alu_V     <= accept_s ? cmd_v : alu_V;
            alu_WR    <= wr_nxt_s;
            alu_ENADi <= en_nxt_s;
            alu_opFL  <= opfl_nxt_s;
            res_valid <= (state_nxt_s == S_DONE);
            res1      <= res1_nxt_s;
            res2      <= res2_nxt_s;
            res_fl    <= fl_nxt_s;
            err       <= err_nxt_s;
        end
    end

    // Command latch, loaded on the accepting edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_r   <= 6'b000000;
            flop_r <= 1'b0;
            opfl_r <= 3'b000;
            a_r    <= 16'h0000;
            b_r    <= 16'h0000;
            d_r    <= 16'h0000;
        end else if (accept_s) begin
            op_r   <= cmd_op;
            flop_r <= cmd_flop;
            opfl_r <= cmd_opfl;
            a_r    <= cmd_a;
            b_r    <= cmd_b;
            d_r    <= cmd_d;
        end else begin
            op_r   <= op_r;
            flop_r <= flop_r;
            opfl_r <= opfl_r;
            a_r    <= a_r;
            b_r    <= b_r;
            d_r    <= d_r;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small ALU/product-unit model drives the main instance,
// a second TIMEOUT=8 instance sees a fixed ALU with a bench-controlled done pulse.
module tb_alu_sequencer;

    logic        CLK        = 1'b0;
    logic        RST        = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic        cmd_valid8 = 1'b0;
    logic [5:0]  cmd_op     = 6'b000000;
    logic        cmd_v      = 1'b0;
    logic        cmd_flop   = 1'b0;
    logic [2:0]  cmd_opfl   = 3'b000;
    logic [15:0] cmd_a      = 16'h0000;
    logic [15:0] cmd_b      = 16'h0000;
    logic [15:0] cmd_d      = 16'h0000;
    logic        finp8      = 1'b0;

    logic        cmd_ready, alu_WA, alu_WB, alu_WD, alu_V, alu_ENADi, alu_FINP, res_valid, err;
    logic [15:0] alu_A, alu_R1, alu_R2, res1, res2;
    logic [5:0]  alu_op, alu_FL, res_fl;
    logic [1:0]  alu_WR;
    logic [2:0]  alu_opFL;

    logic        cmd_ready8, alu_WA8, alu_WB8, alu_WD8, alu_V8, alu_ENADi8, res_valid8, err8;
    logic [15:0] alu_A8, res1_8, res2_8;
    logic [5:0]  alu_op8, res_fl8;
    logic [1:0]  alu_WR8;
    logic [2:0]  alu_opFL8;

    always #5 CLK = ~CLK;

    alu_sequencer #(.TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_v(cmd_v), .cmd_flop(cmd_flop), .cmd_opfl(cmd_opfl),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
        .alu_A(alu_A), .alu_WA(alu_WA), .alu_WB(alu_WB), .alu_WD(alu_WD),
        .alu_op(alu_op), .alu_V(alu_V), .alu_WR(alu_WR), .alu_ENADi(alu_ENADi),
        .alu_opFL(alu_opFL), .alu_R1(alu_R1), .alu_R2(alu_R2), .alu_FL(alu_FL),
        .alu_FINP(alu_FINP), .res_valid(res_valid), .res1(res1), .res2(res2),
        .res_fl(res_fl), .err(err)
    );

    alu_sequencer #(.TIMEOUT(8)) dut8 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_op(cmd_op), .cmd_v(cmd_v), .cmd_flop(cmd_flop), .cmd_opfl(cmd_opfl),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
        .alu_A(alu_A8), .alu_WA(alu_WA8), .alu_WB(alu_WB8), .alu_WD(alu_WD8),
        .alu_op(alu_op8), .alu_V(alu_V8), .alu_WR(alu_WR8), .alu_ENADi(alu_ENADi8),
        .alu_opFL(alu_opFL8), .alu_R1(16'hBEEF), .alu_R2(16'h1234), .alu_FL(6'b010000),
        .alu_FINP(finp8), .res_valid(res_valid8), .res1(res1_8), .res2(res2_8),
        .res_fl(res_fl8), .err(err8)
    );

    // ALU model; flags are {2'b00, OF, SF, ZF, CF} and read through while being written.
    logic [15:0] ra = 16'h0000, rb = 16'h0000, rd = 16'h0000;
    logic [5:0]  fl_r = 6'b000000;
    int          pcnt = 0;
    logic [16:0] sum_m;
    logic [31:0] dvd_m, quo_m, rem_m;
    logic        cf_m, of_m;
    logic [5:0]  fl_m;

    always @(posedge CLK) begin
        if (alu_WA) ra <= alu_A;
        if (alu_WB) rb <= alu_A;
        if (alu_WD) rd <= alu_A;
        if (alu_WR == 2'b01 || alu_opFL != 3'b000) fl_r <= alu_FL;
        if (alu_ENADi) pcnt <= 17;
        else if (pcnt > 0) pcnt <= pcnt - 1;
    end

    assign alu_FINP = (pcnt == 1);

    always_comb begin
        sum_m  = {1'b0, ra} + {1'b0, rb};
        dvd_m  = {rd, ra};
        quo_m  = 32'h0;
        rem_m  = 32'h0;
        alu_R1 = 16'h0000;
        alu_R2 = 16'h0000;
        cf_m   = 1'b0;
        of_m   = 1'b0;
        case (alu_op)
            6'b000000: begin
                alu_R1 = sum_m[15:0];
                cf_m   = sum_m[16];
                of_m   = (ra[15] == rb[15]) && (sum_m[15] != ra[15]);
            end
            6'b101000: alu_R1 = ~ra;
            6'b100101: begin
                if (rb != 16'h0000) begin
                    quo_m  = dvd_m / {16'h0000, rb};
                    rem_m  = dvd_m % {16'h0000, rb};
                    alu_R1 = quo_m[15:0];
                    alu_R2 = rem_m[15:0];
                end
            end
            default: alu_R1 = 16'h0000;
        endcase
        fl_m = {2'b00, of_m, alu_R1[15], (alu_R1 == 16'h0000), cf_m};
        if (alu_WR == 2'b01) alu_FL = fl_m;
        else if (alu_opFL == 3'b100) alu_FL = fl_r | 6'b000001;
        else alu_FL = fl_r;
    end

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [5:0]  fl;
        logic        e;
        int          lat;
        bit          chk_fl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   rel, wa_rel, wb_rel, wb_cnt, wd_cnt, en_cnt, wr01_cnt, wr01_rel, wr10_cnt, opfl_cnt;
    int   rv_cnt, rv_rel;
    logic [15:0] g_r1, g_r2;
    logic [5:0]  g_fl;
    logic        g_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic clear_rec();
        rel = 0; wa_rel = -1; wb_rel = -1; wb_cnt = 0; wd_cnt = 0; en_cnt = 0;
        wr01_cnt = 0; wr01_rel = -1; wr10_cnt = 0; opfl_cnt = 0; rv_cnt = 0; rv_rel = -1;
    endtask

    // One cycle: sample the selected instance half a period after the active edge.
    task automatic tick(input bit sel);
        logic       wa, wb, wd, en, rv;
        logic [1:0] wr;
        logic [2:0] ofl;
        @(negedge CLK);
        rel++;
        wa  = sel ? alu_WA8    : alu_WA;
        wb  = sel ? alu_WB8    : alu_WB;
        wd  = sel ? alu_WD8    : alu_WD;
        en  = sel ? alu_ENADi8 : alu_ENADi;
        rv  = sel ? res_valid8 : res_valid;
        wr  = sel ? alu_WR8    : alu_WR;
        ofl = sel ? alu_opFL8  : alu_opFL;
        if (wa && wa_rel < 0) wa_rel = rel;
        if (wb) begin wb_cnt++; if (wb_rel < 0) wb_rel = rel; end
        if (wd) wd_cnt++;
        if (en) en_cnt++;
        if (wr == 2'b01) begin wr01_cnt++; if (wr01_rel < 0) wr01_rel = rel; end
        if (wr == 2'b10) wr10_cnt++;
        if (ofl != 3'b000) opfl_cnt++;
        if (rv) begin
            rv_cnt++;
            if (rv_rel < 0) begin
                rv_rel = rel;
                g_r1   = sel ? res1_8  : res1;
                g_r2   = sel ? res2_8  : res2;
                g_fl   = sel ? res_fl8 : res_fl;
                g_err  = sel ? err8    : err;
            end
        end
    endtask

    task automatic run_cmd(input string name, input bit sel, input logic [5:0] op,
                           input logic flop, input logic [2:0] opfl, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] d, input exp_t e,
                           input int finp_at);
        exp_t x;
        sb.push_back(e);
        cmd_op = op; cmd_flop = flop; cmd_opfl = opfl; cmd_a = a; cmd_b = b; cmd_d = d;
        if (sel) cmd_valid8 = 1'b1;
        else cmd_valid = 1'b1;
        clear_rec();
        do begin
            tick(sel);
            cmd_valid  = 1'b0;
            cmd_valid8 = 1'b0;
            finp8      = (rel == finp_at);
        end while (rv_cnt == 0 && rel < 40);
        tick(sel);
        finp8 = 1'b0;
        check({name, "_res_valid_pulses"}, 32'(rv_cnt), 32'd1);
        x = sb.pop_front();
        check({name, "_latency"}, 32'(rv_rel), 32'(x.lat));
        check({name, "_res1"}, 32'(g_r1), 32'(x.r1));
        check({name, "_res2"}, 32'(g_r2), 32'(x.r2));
        check({name, "_err"}, 32'(g_err), 32'(x.e));
        if (x.chk_fl) check({name, "_res_fl"}, 32'(g_fl), 32'(x.fl));
        check({name, "_wr10"}, 32'(wr10_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_cmd_ready8", 32'(cmd_ready8), 32'd1);
        check("rst_res_valid_err", 32'({res_valid, err}), 32'd0);
        check("rst_strobes", 32'({alu_WA, alu_WB, alu_WD, alu_ENADi}), 32'd0);
        check("rst_wr", 32'(alu_WR), 32'd0);
        check("rst_opfl", 32'(alu_opFL), 32'd0);
        RST = 1'b0;

        cmd_v = 1'b1;
        run_cmd("add", 1'b0, 6'b000000, 1'b0, 3'b000, 16'h7FFF, 16'h0001, 16'h0000,
                '{16'h8000, 16'h0000, 6'b001100, 1'b0, 4, 1'b1}, 0);
        check("add_wa_cycle", 32'(wa_rel), 32'd1);
        check("add_wb_cycle", 32'(wb_rel), 32'd2);
        check("add_wr01_cycle", 32'(wr01_rel), 32'd3);
        check("add_alu_v", 32'(alu_V), 32'd1);
        cmd_v = 1'b0;

        run_cmd("not", 1'b0, 6'b101000, 1'b0, 3'b000, 16'h00FF, 16'h5555, 16'h0000,
                '{16'hFF00, 16'h0000, 6'b000100, 1'b0, 3, 1'b1}, 0);
        check("not_wb_pulses", 32'(wb_cnt), 32'd0);

        run_cmd("div", 1'b0, 6'b100101, 1'b0, 3'b000, 16'h0000, 16'h0010, 16'h0001,
                '{16'h1000, 16'h0000, 6'b000000, 1'b0, 22, 1'b0}, 0);
        check("div_wd_pulses", 32'(wd_cnt), 32'd1);
        check("div_enadi_pulses", 32'(en_cnt), 32'd1);
        check("div_wr01_cycle", 32'(wr01_rel), 32'd22);

        run_cmd("flag", 1'b0, 6'b000000, 1'b1, 3'b100, 16'h0000, 16'h0000, 16'h0000,
                '{16'h0000, 16'h0000, 6'b000001, 1'b0, 2, 1'b1}, 0);
        check("flag_opfl_cycles", 32'(opfl_cnt), 32'd1);
        check("flag_wr01", 32'(wr01_cnt), 32'd0);

        run_cmd("tmo", 1'b1, 6'b100000, 1'b0, 3'b000, 16'h0003, 16'h0004, 16'h0000,
                '{16'h0000, 16'h0000, 6'b010000, 1'b1, 12, 1'b1}, 0);
        check("tmo_wr01", 32'(wr01_cnt), 32'd0);

        run_cmd("tie", 1'b1, 6'b100000, 1'b0, 3'b000, 16'h0003, 16'h0004, 16'h0000,
                '{16'hBEEF, 16'h1234, 6'b010000, 1'b0, 12, 1'b1}, 11);
        check("tie_wr01", 32'(wr01_cnt), 32'd1);

        run_cmd("first", 1'b1, 6'b100000, 1'b0, 3'b000, 16'h0003, 16'h0004, 16'h0000,
                '{16'hBEEF, 16'h1234, 6'b010000, 1'b0, 5, 1'b1}, 4);

        cmd_op = 6'b000000; cmd_flop = 1'b0; cmd_a = 16'h0001; cmd_b = 16'h0002;
        cmd_valid = 1'b1;
        clear_rec();
        tick(1'b0);
        cmd_valid = 1'b0;
        tick(1'b0);
        check("abort_in_ldb", 32'(alu_WB), 32'd1);
        RST = 1'b1;
        tick(1'b0);
        RST = 1'b0;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_controls", 32'({alu_WA, alu_WB, alu_WD, alu_ENADi, alu_WR, alu_opFL}), 32'd0);
        clear_rec();
        repeat (10) tick(1'b0);
        check("abort_no_res_valid", 32'(rv_cnt), 32'd0);
        check("abort_no_commit", 32'(wr01_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the 16-bit ALU datapath. It accepts one operation per valid/ready handshake and drives the ALU operand bus and load strobes in sequence (WA, WB, and WD for 16-bit divides). It then issues the opcode, starts and supervises the multi-cycle product unit when needed, commits flags, and returns R1/R2 plus a flag snapshot on a one-cycle result strobe. It sits between the instruction decoder and the ALU and is the only writer of the ALU control inputs.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in WAITP before the command is aborted with err.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  6  ALU opcode
- cmd_v  in  1  count select passed to ALU V
- cmd_flop  in  1  1 = flag-only command (uses cmd_opfl, ignores cmd_op)
- cmd_opfl  in  3  flag operation code
- cmd_a, cmd_b, cmd_d  in  16 each  operands (D = high dividend word)
- alu_A  out  16  ALU operand bus
- alu_WA, alu_WB, alu_WD  out  1 each  operand register load strobes
- alu_op  out  6  opcode, held from LDA through DONE
- alu_V  out  1  latched cmd_v
- alu_WR  out  2  flag write control
- alu_ENADi  out  1  product unit start
- alu_opFL  out  3  flag operation, nonzero for exactly one cycle
- alu_R1, alu_R2  in  16 each  ALU results
- alu_FL  in  6  ALU flag vector
- alu_FINP  in  1  product unit done
- res_valid  out  1  one-cycle result strobe
- res1, res2  out  16 each  captured results
- res_fl  out  6  captured flags
- err  out  1  high with res_valid when the product unit timed out

## Operation
- All outputs are registered. Reset value of every output is 0, except cmd_ready, which is 1.
- Opcode classes:
  - PROD: op[5:3]=100.
  - UNARY: op[5:3]=101, which skips LDB.
  - NEEDD: op is 100101 or 100111, which adds LDD.
  - All other opcodes are ALU-type (combinational).
- State machine: IDLE, LDA, LDB, LDD, EXEC, WAITP, FLG, DONE.
- IDLE: on cmd_valid, latch all cmd_* fields.
  - If cmd_flop=1, go to FLG.
  - Otherwise go to LDA.
- LDA: alu_A=cmd_a, alu_WA=1.
  - Next state is LDB, or EXEC if UNARY.
- LDB: alu_A=cmd_b, alu_WB=1.
  - Next state is LDD if NEEDD, otherwise EXEC.
- LDD: alu_A=cmd_d, alu_WD=1. Next state is EXEC.
- EXEC, ALU-type: alu_WR=01, res1<=alu_R1, res2<=0. Next state is DONE.
- EXEC, PROD: alu_ENADi=1 for one cycle, timeout counter cleared. Next state is WAITP.
- WAITP: counter increments each cycle.
  - When alu_FINP=1: alu_WR=01, res1<=alu_R1, res2<=alu_R2, go to DONE.
  - When the counter reaches TIMEOUT-1 without FINP: err<=1, res1 and res2 are 0, alu_WR stays 00, go to DONE.
- FLG: alu_opFL=cmd_opfl, alu_WR=00. Next state is DONE.
- DONE: res_valid=1 for one cycle, res_fl<=alu_FL (the post-commit flag vector), err held. Next state is IDLE with cmd_ready=1.
- alu_WR=10 (direct flag load) is never generated.
- When not in an enabling state, alu_A is 0, and the strobes and ENADi are 0.

## Timing
- The accept handshake completes at cycle 0 (cmd_valid and cmd_ready both high at the edge).
- ALU binary op: LDA at c1, LDB at c2, EXEC at c3, res_valid at c4.
- ALU unary op: res_valid at c3.
- Flag-only command: FLG at c1, res_valid at c2.
- PROD op: EXEC at c3 (c4 for NEEDD), then WAITP for N cycles until FINP, then res_valid one cycle after the FINP cycle.
- cmd_valid is ignored outside IDLE. Back-to-back commands need at least one idle cycle between res_valid and the next accept: cmd_ready is high in IDLE only.
- FINP already high on the first WAITP cycle is accepted immediately.
- FINP arriving in the same cycle the timeout is reached: FINP wins and err=0.
- RST mid-command: next cycle is IDLE, all strobes/ENADi/WR/opFL are 0, and no res_valid is produced for the aborted command. The ALU flags keep whatever was already committed.

## Test plan
- Reset: hold RST 2 cycles → cmd_ready=1; res_valid, err, WA/WB/WD, ENADi, WR, opFL all 0.
- ADD (op 000000), a=0x7FFF, b=0x0001 → WA at c1, WB at c2, WR=01 at c3, res_valid at c4 with res1=0x8000, and res_fl showing SF=1, OF=1, ZF=0.
- NOT (op 101000), a=0x00FF → no WB pulse; res_valid at c3 with res1=0xFF00.
- DIV 16-bit (op 100101), d=0x0001, a=0x0000, b=0x0010, model FINP after 17 cycles → WD pulse, one ENADi pulse, res1=0x1000, res2=0x0000, err=0.
- PROD op with FINP never asserted, TIMEOUT=8 → err=1 with res_valid 8 WAITP cycles after EXEC; res1=0; WR never 01.
- Flag command cmd_flop=1, cmd_opfl=3'b100 (set CF), followed by RST asserted during LDB of the next ADD → opFL=100 for exactly 1 cycle and res_valid at c2; after the reset, IDLE with no res_valid for the aborted ADD.
